// File: rtl/alu_op_queue_if.sv
// alu_op_queue_if
//   Bundles the request handshake, the ALU drive/return path and the
//   result handshake of alu_op_queue.
//   slave  : the queue side (alu_op_queue uses this modport)
//   master : the environment side (producer, consumer and ALU)
//   Signals:
//     in_valid/in_ready, in_a, in_b, in_op, in_tag  - request channel
//     alu_a, alu_b, alu_op, alu_c                    - combinational ALU path
//     out_valid/out_ready, out_c, out_tag, out_zero  - result channel
//     count                                          - queued entries
interface alu_op_queue_if #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CW    = $clog2(DEPTH) + 1
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [2:0]       in_op;
    logic [TAG_W-1:0] in_tag;

    logic [31:0]      alu_a;
    logic [31:0]      alu_b;
    logic [2:0]       alu_op;
    logic [31:0]      alu_c;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_c;
    logic [TAG_W-1:0] out_tag;
    logic             out_zero;

    logic [CW-1:0]    count;

    modport slave (
        input  in_valid, in_a, in_b, in_op, in_tag, alu_c, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_tag,
               out_zero, count
    );

    modport master (
        output in_valid, in_a, in_b, in_op, in_tag, alu_c, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_c, out_tag,
               out_zero, count
    );
endinterface

// File: rtl/alu_op_queue.sv
// alu_op_queue
//   Operand issue queue in front of the combinational ALU. Requests are
//   buffered in a DEPTH-entry circular FIFO; the head entry drives the ALU
//   and its result is captured into a registered, tagged result slot.
//   Ports:
//     clk   - rising-edge clock
//     reset - synchronous, active-low reset
//     bus   - alu_op_queue_if.slave (request, ALU and result channels)
module alu_op_queue #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           reset,
    alu_op_queue_if.slave  bus
);
    localparam int DATA_W = 32;
    localparam int PW     = $clog2(DEPTH);

    function automatic logic is_zero(input logic [DATA_W-1:0] v);
        return (v == '0);
    endfunction

    // queue storage: data only, never reset
    logic [DATA_W-1:0] a_mem   [DEPTH];
    logic [DATA_W-1:0] b_mem   [DEPTH];
    logic [2:0]        op_mem  [DEPTH];
    logic [TAG_W-1:0]  tag_mem [DEPTH];

    logic [PW-1:0]     rp;
    logic [PW-1:0]     wp;
    logic [CW-1:0]     cnt;
    logic [CW-1:0]     cnt_nxt;

    logic              in_ready;
    logic              push;
    logic              not_empty;
    logic              load;

    // result slot (stage p1)
    logic              vld_p1;
    logic [DATA_W-1:0] c_p1;
    logic [TAG_W-1:0]  tag_p1;
    logic              zero_p1;

    // full check looks only at count, so a full queue stalls input even
    // when the head is being popped this cycle
    assign in_ready  = (cnt != CW'(DEPTH));
    assign push      = bus.in_valid && in_ready;
    assign not_empty = (cnt != '0);
    assign load      = not_empty && (!vld_p1 || bus.out_ready);

    always_comb begin
        cnt_nxt = cnt;
        if (push && !load) begin
            cnt_nxt = cnt + CW'(1);
        end else if (!push && load) begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    // stage p0: queue write
    always_ff @(posedge clk) begin
        if (push) begin
            a_mem[wp]   <= bus.in_a;
            b_mem[wp]   <= bus.in_b;
            op_mem[wp]  <= bus.in_op;
            tag_mem[wp] <= bus.in_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rp  <= '0;
            wp  <= '0;
            cnt <= '0;
        end else begin
            if (push) begin
                wp <= wp + PW'(1);
            end
            if (load) begin
                rp <= rp + PW'(1);
            end
            cnt <= cnt_nxt;
        end
    end

    // head entry to the ALU; idle queue drives zeros
    assign bus.alu_a  = not_empty ? a_mem[rp]  : '0;
    assign bus.alu_b  = not_empty ? b_mem[rp]  : '0;
    assign bus.alu_op = not_empty ? op_mem[rp] : '0;

    // stage p1: result slot capture
    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_p1  <= 1'b0;
            c_p1    <= '0;
            tag_p1  <= '0;
            zero_p1 <= 1'b1;
        end else if (load) begin
            vld_p1  <= 1'b1;
            c_p1    <= bus.alu_c;
            tag_p1  <= tag_mem[rp];
            zero_p1 <= is_zero(bus.alu_c);
        end else if (vld_p1 && bus.out_ready) begin
            // slot drained with nothing behind it; payload left stale
            vld_p1  <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = vld_p1;
    assign bus.out_c     = c_p1;
    assign bus.out_tag   = tag_p1;
    assign bus.out_zero  = zero_p1;
    assign bus.count     = cnt;
endmodule

// File: tb/tb_alu_op_queue.sv
// tb_alu_op_queue
//   Scoreboard bench for alu_op_queue with a behavioral add/sub ALU on the
//   combinational return path.
module tb_alu_op_queue;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic clk = 1'b0;
    logic reset;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0]      c;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb[$];
    int   results = 0;

    alu_op_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W)) bus ();

    alu_op_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ALU stand-in: 000 add, 001 sub
    assign bus.alu_c = (bus.alu_op == 3'b001) ? (bus.alu_a - bus.alu_b)
                                              : (bus.alu_a + bus.alu_b);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // monitor on the falling edge: scoreboard push/pop and hold stability
    logic             held = 1'b0;
    logic [31:0]      held_c;
    logic [TAG_W-1:0] held_tag;

    always @(negedge clk) begin
        if (!reset) begin
            sb.delete();
            held = 1'b0;
        end else begin
            if (held && bus.out_valid) begin
                chk("hold_c", 64'(bus.out_c), 64'(held_c));
                chk("hold_tag", 64'(bus.out_tag), 64'(held_tag));
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 64'(1), 64'(0));
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("sb_c", 64'(bus.out_c), 64'(e.c));
                    chk("sb_tag", 64'(bus.out_tag), 64'(e.tag));
                    chk("sb_zero", 64'(bus.out_zero), 64'(e.c == 32'd0));
                    results++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.c   = (bus.in_op == 3'b001) ? bus.in_a - bus.in_b : bus.in_a + bus.in_b;
                e.tag = bus.in_tag;
                sb.push_back(e);
            end
            held     = bus.out_valid && !bus.out_ready;
            held_c   = bus.out_c;
            held_tag = bus.out_tag;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] saved_c;
        int          base;

        // reset with a request presented
        reset         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_a      = 32'd99;
        bus.in_b      = 32'd1;
        bus.in_op     = 3'b000;
        bus.in_tag    = 4'd9;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
        chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
        chk("rst_out_c", 64'(bus.out_c), 64'(0));
        chk("rst_count", 64'(bus.count), 64'(0));
        chk("rst_out_zero", 64'(bus.out_zero), 64'(1));
        chk("rst_alu_a", 64'(bus.alu_a), 64'(0));
        bus.in_valid = 1'b0;
        reset        = 1'b1;
        step();
        chk("rst_none_acc", 64'(bus.count), 64'(0));

        // single op
        bus.in_valid = 1'b1;
        bus.in_a = 32'd5; bus.in_b = 32'd3; bus.in_op = 3'b000; bus.in_tag = 4'd1;
        step();
        bus.in_valid = 1'b0;
        chk("single_early", 64'(bus.out_valid), 64'(0));
        step();
        chk("single_valid", 64'(bus.out_valid), 64'(1));
        chk("single_c", 64'(bus.out_c), 64'(8));
        chk("single_tag", 64'(bus.out_tag), 64'(1));
        chk("single_zero", 64'(bus.out_zero), 64'(0));
        step();
        chk("single_drain", 64'(bus.out_valid), 64'(0));

        // zero flag
        bus.in_valid = 1'b1;
        bus.in_a = 32'd7; bus.in_b = 32'd7; bus.in_op = 3'b001; bus.in_tag = 4'd2;
        step();
        bus.in_valid = 1'b0;
        step();
        chk("zero_valid", 64'(bus.out_valid), 64'(1));
        chk("zero_c", 64'(bus.out_c), 64'(0));
        chk("zero_flag", 64'(bus.out_zero), 64'(1));
        chk("zero_tag", 64'(bus.out_tag), 64'(2));
        step();

        // backpressure and full
        bus.out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'(i * 10);
            bus.in_b     = 32'(i);
            bus.in_op    = 3'b000;
            bus.in_tag   = TAG_W'(i);
            chk("bp_in_ready", 64'(bus.in_ready), 64'(i < 5));
            step();
        end
        bus.in_valid = 1'b0;
        chk("bp_count", 64'(bus.count), 64'(4));
        chk("bp_valid", 64'(bus.out_valid), 64'(1));
        chk("bp_head_tag", 64'(bus.out_tag), 64'(0));
        saved_c = bus.out_c;
        step();
        step();
        chk("bp_stable", 64'(bus.out_c), 64'(saved_c));
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            chk("rel_valid", 64'(bus.out_valid), 64'(1));
            chk("rel_tag", 64'(bus.out_tag), 64'(k));
            chk("rel_c", 64'(bus.out_c), 64'(k * 11));
            step();
        end
        chk("rel_done", 64'(bus.out_valid), 64'(0));
        chk("rel_sb_empty", 64'(sb.size()), 64'(0));

        // streaming across pointer wrap
        base = results;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'(i);
            bus.in_b     = 32'd1;
            bus.in_op    = 3'b000;
            bus.in_tag   = TAG_W'(i % 16);
            chk("stream_rdy", 64'(bus.in_ready), 64'(1));
            chk("stream_cnt", 64'(bus.count <= CW'(1)), 64'(1));
            if (i >= 2) chk("stream_valid", 64'(bus.out_valid), 64'(1));
            step();
        end
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        chk("stream_results", 64'(results - base), 64'(20));
        chk("stream_sb_empty", 64'(sb.size()), 64'(0));

        // reset mid-operation
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_a     = 32'(100 + i);
            bus.in_b     = 32'd0;
            bus.in_op    = 3'b000;
            bus.in_tag   = TAG_W'(i + 8);
            step();
        end
        bus.in_valid = 1'b0;
        chk("mid_count", 64'(bus.count), 64'(3));
        chk("mid_valid", 64'(bus.out_valid), 64'(1));
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("mid_rst_count", 64'(bus.count), 64'(0));
        chk("mid_rst_valid", 64'(bus.out_valid), 64'(0));
        chk("mid_rst_c", 64'(bus.out_c), 64'(0));
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_a = 32'd1; bus.in_b = 32'd2; bus.in_op = 3'b000; bus.in_tag = 4'd7;
        step();
        bus.in_valid = 1'b0;
        chk("post_early", 64'(bus.out_valid), 64'(0));
        step();
        chk("post_valid", 64'(bus.out_valid), 64'(1));
        chk("post_c", 64'(bus.out_c), 64'(3));
        chk("post_tag", 64'(bus.out_tag), 64'(7));
        step();
        chk("post_drain", 64'(bus.out_valid), 64'(0));
        chk("post_sb_empty", 64'(sb.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_op_queue.md
# alu_op_queue

Operand issue queue sitting directly upstream of the combinational `alu` in the execute path. Buffers up to DEPTH tagged operation requests (A, B, ALUOp, tag) behind a valid/ready handshake, presents the head entry to the ALU, and captures the ALU's C into a registered, tagged result slot with its own valid/ready handshake. Lets producers and consumers stall independently while sustaining one ALU operation per cycle.

## Interface

- DEPTH, 4, queue entries; power of two, ≥2
- TAG_W, 4, width of request/result tag
- CW, $clog2(DEPTH)+1, width of `count`
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-low reset: sampled on rising clk edge, asserted when 0
- in_valid  input  1  request present
- in_ready  output  1  queue can accept
- in_a  input  32  operand A
- in_b  input  32  operand B
- in_op  input  3  ALUOp
- in_tag  input  TAG_W  request tag
- alu_a  output  32  to alu.A
- alu_b  output  32  to alu.B
- alu_op  output  3  to alu.ALUOp
- alu_c  input  32  from alu.C (combinational)
- out_valid  output  1  result slot full
- out_ready  input  1  consumer accepts result
- out_c  output  32  registered result
- out_tag  output  TAG_W  tag of result
- out_zero  output  1  out_c == 0
- count  output  CW  entries currently queued (excludes result slot)

## Operation

- Storage: circular buffer, DEPTH entries, read pointer rp, write pointer wp (log2 DEPTH bits, wrap modulo DEPTH), count register 0..DEPTH.
- Push = in_valid && in_ready; writes entry at wp, wp+1.
- in_ready = (count != DEPTH); no dependence on out_ready or on a same-cycle pop (full queue stalls input even if popping).
- ALU drive: when count>0, alu_a/alu_b/alu_op = head entry fields; when count==0, all drive 0.
- Load = (count>0) && (!out_valid || out_ready). On load: out_c<=alu_c, out_tag<=head tag, out_zero<=(alu_c==0), out_valid<=1, rp+1 (pop).
- If out_valid && out_ready && !load: out_valid<=0; out_c/out_tag/out_zero hold stale values.
- Simultaneous push and pop: count unchanged; both pointers advance. Push into empty queue: entry not visible to ALU until next cycle (no bypass).
- Order strictly FIFO; tags pass through unmodified; no reordering, no dropping.
- Data on in_* ignored when in_valid=0 or in_ready=0; out_c/out_tag must stay stable while out_valid=1 and out_ready=0.

## Timing

- Reset (reset=0 at edge): count=0, rp=wp=0, out_valid=0, out_c=0, out_tag=0, out_zero=1 (reflects out_c=0); consequently in_ready=1, alu_a=alu_b=0, alu_op=0. Reset mid-operation discards all queued entries and the result slot; requests presented during reset are not accepted.
- Latency: request accepted at edge N into empty queue with free slot -> out_valid=1 with its result after edge N+1 (2 edges).
- Throughput: 1 result/cycle when in_valid and out_ready held high.
- Full: count==DEPTH -> in_ready=0 same cycle (combinational from count).
- Backpressure: out_ready=0 with out_valid=1 -> no pop; queue fills to DEPTH, then in_ready=0. Total buffering = DEPTH+1 requests.
- Pointer wrap: wp/rp roll from DEPTH-1 to 0 with no gap or duplicate.

## Test plan

Bench instantiates this block wired to the team's `alu` (ALUOp 3'b000 = add, 3'b001 = sub).

- Reset: hold reset=0 two cycles with in_valid=1 -> in_ready=1, out_valid=0, out_c=0, count=0, out_zero=1, alu_a=0; no entry accepted.
- Single op: push A=5, B=3, op=0, tag=1, out_ready=1 -> two edges later out_valid=1, out_c=8, out_tag=1, out_zero=0; next cycle out_valid=0.
- Zero flag: push A=7, B=7, op=1, tag=2 -> out_c=0, out_zero=1, out_tag=2.
- Backpressure/full: out_ready=0, push 6 requests tags 0..5 -> 5 accepted (slot + 4), count=4, in_ready=0 on 6th; release out_ready -> results emerge tags 0..4 in order, one per cycle, out_c held stable while stalled.
- Streaming wrap: in_valid=1, out_ready=1 for 20 cycles, A=i, B=1, op=0, tag=i mod 16 -> results i+1 every cycle after initial 2-edge latency, count never exceeds 1, no skipped tags.
- Reset mid-operation: with count=3 and out_valid=1, assert reset one cycle -> count=0, out_valid=0; subsequent push A=1,B=2,op=0 yields out_c=3 with no stale results.
